// File: rtl/ic_check_pkg.sv
// Shared types and constants for the exhaustive invertibility-condition sweep checkers.
package ic_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEARCH,
    COMPARE,
    DONE
  } state_t;

  // Both s and t start their ascending sweep here; s is the outer loop.
  localparam int ENUM_FIRST = 0;

  // The counter must hold 2^(2W), i.e. every pair mismatching.
  function automatic int cw_of(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/ic_bvsge_bvlshr_eval.sv
// Combinational predicate (x >>u s) >=s t; one evaluation per call, no state.
module ic_bvsge_bvlshr_eval #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         ge
);

  localparam logic [W:0] WIDTH_V = (W + 1)'(W);

  logic [W-1:0] y;

  always_comb begin
    y  = ({1'b0, s} >= WIDTH_V) ? '0 : (x >> s);
    ge = ($signed(y) >= $signed(t));
  end

endmodule

// File: rtl/ic_bvsge_bvlshr_sweep_checker.sv
// Sweeps every (s,t) through the external bvsge/bvlshr IC block, brute-forces x, counts disagreements.
// Latency 2+k cycles per pair (k=1..2^W); no backpressure: start ignored while busy, abort always wins.
module ic_bvsge_bvlshr_sweep_checker
  import ic_check_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = cw_of(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [W-1:0]  s_o,
  output logic [W-1:0]  t_o,
  input  logic          ic_i,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] mismatch_cnt,
  output logic [W-1:0]  first_fail_s,
  output logic [W-1:0]  first_fail_t
);

  localparam logic [W-1:0]  ALL1    = {W{1'b1}};
  localparam logic [W-1:0]  FIRST   = W'(ENUM_FIRST);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t       state, state_n;
  logic [W-1:0] x;
  logic         found;
  logic         hit;
  logic         last_x;
  logic         last_pair;
  logic         mism;

  ic_bvsge_bvlshr_eval #(.W(W)) u_eval (
    .x  (x),
    .s  (s_o),
    .t  (t_o),
    .ge (hit)
  );

  assign last_x    = (x == ALL1);
  assign last_pair = (s_o == ALL1) && (t_o == ALL1);
  assign mism      = (ic_i != found);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_n = LOAD;
        LOAD:    state_n = SEARCH;
        SEARCH:  if (hit || last_x) state_n = COMPARE;
        COMPARE: state_n = last_pair ? DONE : LOAD;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    busy = (state == LOAD) || (state == SEARCH) || (state == COMPARE);
    done = (state == DONE) && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_o          <= '0;
      t_o          <= '0;
      x            <= '0;
      found        <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      first_fail_s <= '0;
      first_fail_t <= '0;
    end else if (abort) begin
      pass <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s_o          <= FIRST;
            t_o          <= FIRST;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            first_fail_s <= '0;
            first_fail_t <= '0;
          end
        end
        LOAD: begin
          x     <= '0;
          found <= 1'b0;
        end
        SEARCH: begin
          if (hit)          found <= 1'b1;
          else if (!last_x) x     <= x + 1'b1;
        end
        COMPARE: begin
          if (mism) begin
            if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + 1'b1;
            if (mismatch_cnt == '0) begin
              first_fail_s <= s_o;
              first_fail_t <= t_o;
            end
          end
          // t is the inner loop; s steps only when t wraps.
          t_o <= t_o + 1'b1;
          if (t_o == ALL1) s_o <= s_o + 1'b1;
          if (last_pair) pass <= (mismatch_cnt == '0) && !mism;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ic_bvsge_bvlshr_sweep_checker.sv
// Bench: drives ic_i from a brute-force reference (optionally corrupted) and checks sweep results.
module tb_ic_bvsge_bvlshr_sweep_checker;

  localparam int W  = 4;
  localparam int CW = 9;
  localparam int NV = 16;
  localparam int NP = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          ic_i;
  logic          busy;
  logic          done;
  logic          pass;
  logic [W-1:0]  s_o;
  logic [W-1:0]  t_o;
  logic [W-1:0]  first_fail_s;
  logic [W-1:0]  first_fail_t;
  logic [CW-1:0] mismatch_cnt;

  int vectors     = 0;
  int miscompares = 0;

  int mode;
  bit golden [NP];
  bit fault  [NP];
  int dur    [NP];

  bit got_done, order_ok, d_pass, done_after, busy_after;
  int d_cnt, d_ffs, d_fft;

  always #5 clk = ~clk;

  ic_bvsge_bvlshr_sweep_checker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .s_o          (s_o),
    .t_o          (t_o),
    .ic_i         (ic_i),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .mismatch_cnt (mismatch_cnt),
    .first_fail_s (first_fail_s),
    .first_fail_t (first_fail_t)
  );

  always_comb begin
    case (mode)
      0:       ic_i = golden[{s_o, t_o}];
      1:       ic_i = 1'b1;
      2:       ic_i = 1'b0;
      default: ic_i = golden[{s_o, t_o}] ^ fault[{s_o, t_o}];
    endcase
  end

  function automatic int to_signed(input int v);
    return (v >= NV / 2) ? v - NV : v;
  endfunction

  // Index of the first x satisfying the predicate, or NV if none does.
  function automatic int first_x(input int s, input int t);
    int y;
    for (int x = 0; x < NV; x++) begin
      y = (s >= W) ? 0 : (x >> s);
      if (to_signed(y) >= to_signed(t)) return x;
    end
    return NV;
  endfunction

  function automatic int search_len(input int s, input int t);
    int fx;
    fx = first_x(s, t);
    return (fx == NV) ? NV : fx + 1;
  endfunction

  function automatic bit exp_ic(input int m, input int idx);
    case (m)
      0:       return golden[idx];
      1:       return 1'b1;
      2:       return 1'b0;
      default: return golden[idx] ^ fault[idx];
    endcase
  endfunction

  task automatic do_sweep(input int hold);
    int prev;
    int cyc;
    int idx;
    for (int i = 0; i < NP; i++) dur[i] = 0;
    got_done = 1'b0;
    order_ok = 1'b1;
    prev     = -1;
    cyc      = 0;
    @(posedge clk);
    #1 start = 1'b1;
    while (!got_done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc > hold + 1) start = 1'b0;
      if (busy === 1'b1) begin
        idx = int'({s_o, t_o});
        dur[idx]++;
        if (idx != prev) begin
          if (idx != prev + 1) order_ok = 1'b0;
          prev = idx;
        end
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        d_pass   = pass;
        d_cnt    = int'(mismatch_cnt);
        d_ffs    = int'(first_fail_s);
        d_fft    = int'(first_fail_t);
      end
    end
    start = 1'b0;
    if (prev != NP - 1) order_ok = 1'b0;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    #22;
    vectors++;
    if ({busy, done, pass, mismatch_cnt, first_fail_s, first_fail_t, s_o, t_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_values got busy=%b done=%b pass=%b cnt=%0d ff=(%0d,%0d) st=(%0d,%0d) want all 0",
               busy, done, pass, mismatch_cnt, first_fail_s, first_fail_t, s_o, t_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_golden();
    int bad;
    mode = 0;
    do_sweep(0);
    vectors++;
    if (got_done !== 1'b1) begin
      miscompares++;
      $display("FAIL golden_done got %b want 1", got_done);
    end
    vectors++;
    if (d_pass !== 1'b1) begin
      miscompares++;
      $display("FAIL golden_pass got %b want 1", d_pass);
    end
    vectors++;
    if (d_cnt != 0) begin
      miscompares++;
      $display("FAIL golden_cnt got %0d want 0", d_cnt);
    end
    vectors++;
    if (order_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL golden_order got %b want 1", order_ok);
    end
    bad = 0;
    for (int i = 0; i < NP; i++)
      if (dur[i] != 2 + search_len(i / NV, i % NV)) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL pair_latency_table got %0d wrong pairs want 0", bad);
    end
    vectors++;
    if ({done_after, busy_after} !== 2'b00) begin
      miscompares++;
      $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done_after, busy_after);
    end
  endtask

  task automatic test_pair_timing();
    mode = 0;
    do_sweep(0);
    vectors++;
    if (dur[2 * NV + 7] != 2 + search_len(2, 7)) begin
      miscompares++;
      $display("FAIL timing_s2_t7 got %0d cycles want %0d", dur[2 * NV + 7], 2 + search_len(2, 7));
    end
    vectors++;
    if (dur[0] != 2 + search_len(0, 0)) begin
      miscompares++;
      $display("FAIL timing_s0_t0 got %0d cycles want %0d", dur[0], 2 + search_len(0, 0));
    end
  endtask

  task automatic test_fault_modes();
    int ecnt;
    int efirst;
    for (int m = 1; m <= 3; m++) begin
      if (m == 3) begin
        for (int i = 0; i < NP; i++) fault[i] = ($urandom_range(7) == 0);
        fault[$urandom_range(NP - 1)] = 1'b1;
      end
      mode   = m;
      ecnt   = 0;
      efirst = 0;
      for (int i = 0; i < NP; i++) begin
        if (exp_ic(m, i) != golden[i]) begin
          if (ecnt == 0) efirst = i;
          ecnt++;
        end
      end
      do_sweep(0);
      vectors++;
      if (got_done !== 1'b1) begin
        miscompares++;
        $display("FAIL mode%0d_done got %b want 1", m, got_done);
      end
      vectors++;
      if (d_cnt != ecnt) begin
        miscompares++;
        $display("FAIL mode%0d_cnt got %0d want %0d", m, d_cnt, ecnt);
      end
      vectors++;
      if (d_ffs != efirst / NV || d_fft != efirst % NV) begin
        miscompares++;
        $display("FAIL mode%0d_first got (%0d,%0d) want (%0d,%0d)", m, d_ffs, d_fft, efirst / NV, efirst % NV);
      end
      vectors++;
      if (d_pass !== (ecnt == 0)) begin
        miscompares++;
        $display("FAIL mode%0d_pass got %b want %b", m, d_pass, ecnt == 0);
      end
    end
  endtask

  task automatic test_abort();
    int ecnt;
    int cyc;
    bit seen;
    bit stray;
    mode = 1;
    ecnt = 0;
    for (int i = 0; i < 5 * NV + 3; i++) if (!golden[i]) ecnt++;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1 && {s_o, t_o} === 8'h53) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL abort_reach_pair got timeout want pair (5,3)");
    end else begin
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, pass, s_o, t_o} !== {2'b00, 8'h53}) begin
        miscompares++;
        $display("FAIL abort_state got busy=%b pass=%b st=(%0d,%0d) want 0 0 (5,3)", busy, pass, s_o, t_o);
      end
      vectors++;
      if (int'(mismatch_cnt) != ecnt) begin
        miscompares++;
        $display("FAIL abort_cnt_hold got %0d want %0d", mismatch_cnt, ecnt);
      end
      stray = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
      end
      vectors++;
      if (stray) begin
        miscompares++;
        $display("FAIL abort_quiet got done/busy activity want none");
      end
    end
    do_sweep(0);
    vectors++;
    if (!got_done || !order_ok || d_cnt != 94) begin
      miscompares++;
      $display("FAIL abort_restart got done=%b order=%b cnt=%0d want 1 1 94", got_done, order_ok, d_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit stray;
    mode = 1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (1200) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, pass, mismatch_cnt, first_fail_s, first_fail_t, s_o, t_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async got busy=%b pass=%b cnt=%0d ff=(%0d,%0d) st=(%0d,%0d) want all 0",
               busy, pass, mismatch_cnt, first_fail_s, first_fail_t, s_o, t_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    vectors++;
    if (stray) begin
      miscompares++;
      $display("FAIL reset_mid_quiet got done/busy activity want none");
    end
  endtask

  task automatic test_start_held();
    mode = 0;
    do_sweep(300);
    vectors++;
    if (!got_done || !order_ok || !d_pass || d_cnt != 0) begin
      miscompares++;
      $display("FAIL start_held got done=%b order=%b pass=%b cnt=%0d want 1 1 1 0", got_done, order_ok, d_pass, d_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      golden[i] = (first_x(i / NV, i % NV) != NV);
      fault[i]  = 1'b0;
    end
    test_reset();
    test_golden();
    test_pair_timing();
    test_fault_modes();
    test_abort();
    test_reset_mid();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
